// File: rtl/jtkicker_romslot_pkg.sv
// Shared types and constants for the kicker 32-bit SDRAM ROM slot.
package jtkicker_romslot_pkg;

    localparam int SDRAM_AW = 22;
    localparam int BEATS    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BEAT0 = 2'd2,
        BEAT1 = 2'd3
    } state_t;

    // Absolute halfword address of a slot-relative halfword address, wrapping at 2^22.
    function automatic logic [SDRAM_AW-1:0] slot_addr(
        input logic [SDRAM_AW-1:0] offset,
        input logic [SDRAM_AW-1:0] haddr
    );
        return offset + haddr;
    endfunction

endpackage

// File: rtl/jtkicker_romslot32_if.sv
// SDRAM request/ack/data bus between a ROM slot (master) and the SDRAM arbiter (slave).
interface jtkicker_romslot32_if;
    import jtkicker_romslot_pkg::*;

    logic                sdram_req;
    logic                sdram_ack;
    logic [SDRAM_AW-1:0] sdram_addr;
    logic                data_dst;
    logic                data_rdy;
    logic [15:0]         data_read;

    modport master (
        output sdram_req, sdram_addr,
        input  sdram_ack, data_dst, data_rdy, data_read
    );

    modport slave (
        input  sdram_req, sdram_addr,
        output sdram_ack, data_dst, data_rdy, data_read
    );

endinterface

// File: rtl/jtkicker_romslot_entry.sv
// One cache line of the ROM slot: tag, 32-bit data and valid flag with a tag comparator.
module jtkicker_romslot_entry
    import jtkicker_romslot_pkg::*;
#(
    parameter int TW = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                we_lo,
    input  logic                we_hi,
    input  logic                set_valid,
    input  logic [TW-1:0]       wtag,
    input  logic [TW-1:0]       ltag,
    input  logic [15:0]         wdata,
    output logic                match,
    output logic [16*BEATS-1:0] data
);

    logic                valid_r;
    logic [TW-1:0]       tag_r;
    logic [16*BEATS-1:0] data_r;

    // Writing the low half invalidates the line so a half-filled word is never served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            tag_r   <= '0;
            data_r  <= '0;
        end else begin
            if (we_lo) begin
                data_r[15:0] <= wdata;
            end else begin
                data_r[15:0] <= data_r[15:0];
            end
            if (we_hi) begin
                data_r[31:16] <= wdata;
                tag_r         <= wtag;
            end else begin
                data_r[31:16] <= data_r[31:16];
                tag_r         <= tag_r;
            end
            if (clr) begin
                valid_r <= 1'b0;
            end else if (we_hi) begin
                valid_r <= set_valid;
            end else if (we_lo) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign match = valid_r & (tag_r == ltag);
    assign data  = data_r;

endmodule

// File: rtl/jtkicker_romslot32.sv
// Single-client SDRAM ROM slot returning 32-bit words assembled from two 16-bit beats.
// Define JTKICKER_ROMSLOT_2WAY_EN for a two-entry fully associative cache with LRU replacement.
module jtkicker_romslot32
    import jtkicker_romslot_pkg::*;
#(
    parameter int                  AW     = 14,
    parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic                cs,
    input  logic [AW-1:0]       addr,
    output logic [16*BEATS-1:0] dout,
    output logic                ok,
    jtkicker_romslot32_if.master bus
);

`ifdef JTKICKER_ROMSLOT_2WAY_EN
    localparam int WAYS = 2;
`else
    localparam int WAYS = 1;
`endif

    state_t                state_r;
    state_t                state_nx;
    logic                  start_s;
    logic                  lo_we_s;
    logic                  hi_we_s;
    logic                  hit_s;
    logic                  set_valid_s;
    logic                  lru_s;
    logic                  req_r;
    logic [SDRAM_AW-1:0]   sdram_addr_r;
    logic [AW-2:0]         pend_tag_r;
    logic                  victim_r;
    logic                  abort_r;
    logic                  ok_r;
    logic [16*BEATS-1:0]   dout_r;
    logic [16*BEATS-1:0]   hit_data_s;
    logic [15:0]           victim_lo_s;
    logic [SDRAM_AW-1:0]   haddr_s;
    logic [WAYS-1:0]       match_s;
    logic [16*BEATS-1:0]   edata_s [WAYS];
    logic                  unused_s;

    assign unused_s    = addr[0];
    assign haddr_s     = {{(SDRAM_AW-AW){1'b0}}, addr[AW-1:1], 1'b0};
    assign hit_s       = cs & ~downloading & (|match_s);
    assign set_valid_s = ~abort_r & ~downloading;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic sel_s;
        assign sel_s = (victim_r == 1'(w));

        jtkicker_romslot_entry #(.TW(AW-1)) u_entry (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (downloading),
            .we_lo     (lo_we_s & sel_s),
            .we_hi     (hi_we_s & sel_s),
            .set_valid (set_valid_s),
            .wtag      (pend_tag_r),
            .ltag      (addr[AW-1:1]),
            .wdata     (bus.data_read),
            .match     (match_s[w]),
            .data      (edata_s[w])
        );
    end

    // Read mux for the hitting line and the already-stored low half of the victim.
    always_comb begin
        hit_data_s  = '0;
        victim_lo_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_data_s  = hit_data_s | ({(16*BEATS){match_s[w]}} & edata_s[w]);
            victim_lo_s = victim_lo_s | ({16{victim_r == 1'(w)}} & edata_s[w][15:0]);
        end
    end

`ifdef JTKICKER_ROMSLOT_2WAY_EN
    logic lru_r;
    logic hit_way_s;

    assign hit_way_s = match_s[1];
    assign lru_s     = lru_r;

    // LRU pointer: the filled or hit line becomes most recently used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lru_r <= 1'b0;
        end else if (hi_we_s) begin
            lru_r <= ~victim_r;
        end else if (hit_s) begin
            lru_r <= ~hit_way_s;
        end else begin
            lru_r <= lru_r;
        end
    end
`else
    assign lru_s = 1'b0;
`endif

    // Fetch state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next state and beat write strobes; data_rdy alone still closes the burst.
    always_comb begin
        state_nx = state_r;
        start_s  = 1'b0;
        lo_we_s  = 1'b0;
        hi_we_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (cs & ~downloading & ~(|match_s)) begin
                    start_s  = 1'b1;
                    state_nx = REQ;
                end else begin
                    state_nx = IDLE;
                end
            end
            REQ: begin
                if (bus.sdram_ack) begin
                    state_nx = BEAT0;
                end else begin
                    state_nx = REQ;
                end
            end
            BEAT0: begin
                if (bus.data_dst) begin
                    lo_we_s  = 1'b1;
                    state_nx = BEAT1;
                end else begin
                    state_nx = BEAT0;
                end
            end
            BEAT1: begin
                if (bus.data_dst | bus.data_rdy) begin
                    hi_we_s  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = BEAT1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Request side: address, tag and victim are frozen at miss time for the whole fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r        <= 1'b0;
            sdram_addr_r <= '0;
            pend_tag_r   <= '0;
            victim_r     <= 1'b0;
            abort_r      <= 1'b0;
        end else begin
            if (start_s) begin
                req_r        <= 1'b1;
                sdram_addr_r <= slot_addr(OFFSET, haddr_s);
                pend_tag_r   <= addr[AW-1:1];
                victim_r     <= lru_s;
            end else if ((state_r == REQ) && bus.sdram_ack) begin
                req_r        <= 1'b0;
                sdram_addr_r <= sdram_addr_r;
                pend_tag_r   <= pend_tag_r;
                victim_r     <= victim_r;
            end else begin
                req_r        <= req_r;
                sdram_addr_r <= sdram_addr_r;
                pend_tag_r   <= pend_tag_r;
                victim_r     <= victim_r;
            end
            if (start_s) begin
                abort_r <= 1'b0;
            end else if (downloading) begin
                abort_r <= 1'b1;
            end else begin
                abort_r <= abort_r;
            end
        end
    end

    // Requester outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_r   <= 1'b0;
            dout_r <= '0;
        end else begin
            ok_r <= hit_s;
            if (hi_we_s) begin
                dout_r <= {bus.data_read, victim_lo_s};
            end else if (hit_s) begin
                dout_r <= hit_data_s;
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    assign bus.sdram_req  = req_r;
    assign bus.sdram_addr = sdram_addr_r;
    assign dout           = dout_r;
    assign ok             = ok_r;

endmodule

// File: tb/tb_jtkicker_romslot32.sv
// Scoreboard bench for jtkicker_romslot32: request addresses and fill words are queued when driven.
module tb_jtkicker_romslot32;

    localparam logic [21:0] OFFSET = 22'h1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic        cs = 1'b0;
    logic [13:0] addr = 14'h0;
    logic [31:0] dout;
    logic        ok;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] addr_q[$];
    logic [31:0] data_q[$];

    jtkicker_romslot32_if bus();

    jtkicker_romslot32 #(.AW(14), .OFFSET(OFFSET)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .cs          (cs),
        .addr        (addr),
        .dout        (dout),
        .ok          (ok),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_addr(input logic [13:0] a);
        logic [21:0] h;
        logic [21:0] s;
        h = {8'd0, a[13:1], 1'b0};
        s = OFFSET + h;
        return {10'd0, s};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Miss expected: request must show up one cycle later with the queued address.
    task automatic expect_req(input logic [13:0] a);
        int k;
        addr_q.push_back(exp_addr(a));
        k = 0;
        do begin
            tick();
            k++;
        end while (!bus.sdram_req && k < 8);
        check("req_latency", k, 32'd1);
        check("sdram_addr", {10'd0, bus.sdram_addr}, addr_q.pop_front());
    endtask

    task automatic serve(input logic [15:0] lo, input logic [15:0] hi,
                         input bit dl, input bit rdy_only, input bit expect_fill);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        check("req_after_ack", {31'd0, bus.sdram_req}, 32'd0);
        bus.data_dst  = 1'b1;
        bus.data_read = lo;
        downloading   = dl;
        tick();
        bus.data_dst  = !rdy_only;
        bus.data_rdy  = 1'b1;
        bus.data_read = hi;
        tick();
        bus.data_dst  = 1'b0;
        bus.data_rdy  = 1'b0;
        bus.data_read = 16'h0;
        downloading   = 1'b0;
        if (expect_fill) data_q.push_back({hi, lo});
    endtask

    task automatic wait_ok();
        int k;
        k = 1;
        while (!ok && k < 8) begin
            tick();
            k++;
        end
        check("fill_to_ok", k, 32'd2);
        check("dout", dout, data_q.pop_front());
    endtask

    task automatic fill(input logic [13:0] a, input logic [15:0] lo, input logic [15:0] hi);
        addr = a;
        expect_req(a);
        serve(lo, hi, 1'b0, 1'b0, 1'b1);
        wait_ok();
    endtask

    task automatic hold_hit(input int n, input logic [31:0] exp);
        for (int i = 0; i < n; i++) begin
            tick();
            check("hit_ok", {31'd0, ok}, 32'd1);
            check("hit_no_req", {31'd0, bus.sdram_req}, 32'd0);
            check("hit_dout", dout, exp);
        end
    endtask

    initial begin
        bus.sdram_ack = 1'b0;
        bus.data_dst  = 1'b0;
        bus.data_rdy  = 1'b0;
        bus.data_read = 16'h0;
        tick();
        check("rst_req", {31'd0, bus.sdram_req}, 32'd0);
        check("rst_ok", {31'd0, ok}, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_addr", {10'd0, bus.sdram_addr}, 32'd0);
        rst_n = 1'b1;

        // cold miss, then re-hit including the odd halfword of the same word
        cs = 1'b1;
        fill(14'h0012, 16'hBEEF, 16'hDEAD);
        hold_hit(2, 32'hDEADBEEF);
        addr = 14'h0013;
        hold_hit(2, 32'hDEADBEEF);
        cs = 1'b0;
        tick();
        check("ok_cs_low", {31'd0, ok}, 32'd0);

        // burst closed by data_rdy without a second data_dst
        cs   = 1'b1;
        addr = 14'h02A7;
        expect_req(14'h02A7);
        serve(16'h1234, 16'h5678, 1'b0, 1'b1, 1'b1);
        wait_ok();
        hold_hit(1, 32'h56781234);

        // address changes while the request is pending
        addr = 14'h0100;
        expect_req(14'h0100);
        addr = 14'h0040;
        serve(16'hAAAA, 16'hBBBB, 1'b0, 1'b0, 1'b0);
        check("no_ok_mid", {31'd0, ok}, 32'd0);
        expect_req(14'h0040);
        serve(16'hCAFE, 16'hF00D, 1'b0, 1'b0, 1'b1);
        wait_ok();

        // download raised in BEAT0: result must not become valid
        addr = 14'h0200;
        expect_req(14'h0200);
        serve(16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0);
        check("no_ok_after_dl", {31'd0, ok}, 32'd0);
        expect_req(14'h0200);
        serve(16'h3333, 16'h4444, 1'b0, 1'b0, 1'b1);
        wait_ok();

        // download over a hit clears it and blocks requests
        downloading = 1'b1;
        tick();
        check("dl_ok", {31'd0, ok}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("dl_no_req", {31'd0, bus.sdram_req}, 32'd0);
        end
        downloading = 1'b0;
        expect_req(14'h0200);
        serve(16'h5555, 16'h6666, 1'b0, 1'b0, 1'b1);
        wait_ok();

        // asynchronous reset while waiting for the second beat
        addr = 14'h0300;
        expect_req(14'h0300);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        bus.data_dst  = 1'b1;
        bus.data_read = 16'h7777;
        tick();
        bus.data_dst = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", {31'd0, bus.sdram_req}, 32'd0);
        check("arst_ok", {31'd0, ok}, 32'd0);
        check("arst_dout", dout, 32'd0);
        check("arst_addr", {10'd0, bus.sdram_addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        fill(14'h0200, 16'h8888, 16'h9999);

        // replacement: A, B, touch A, C; then A and B again
        fill(14'h0400, 16'hA0A0, 16'hA1A1);
        fill(14'h0500, 16'hB0B0, 16'hB1B1);
`ifdef JTKICKER_ROMSLOT_2WAY_EN
        addr = 14'h0400;
        hold_hit(1, 32'hA1A1A0A0);
`endif
        fill(14'h0600, 16'hC0C0, 16'hC1C1);
`ifdef JTKICKER_ROMSLOT_2WAY_EN
        addr = 14'h0400;
        hold_hit(2, 32'hA1A1A0A0);
`else
        fill(14'h0400, 16'hA2A2, 16'hA3A3);
`endif
        fill(14'h0500, 16'hB2B2, 16'hB3B3);

        cs = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
